// File: rtl/dmem_arb_pkg.sv
// Shared constants for the instruction/data cache memory arbiter:
// widths, FSM state codes, requester IDs and the latched operation type.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF  = 28;
   localparam int BLOCK_W_DEF = 128;
   localparam int TIMEOUT_DEF = 64;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_GRANT = 2'b01;
   localparam logic [1:0] S_DONE  = 2'b10;

   localparam logic REQ_ICACHE = 1'b0;
   localparam logic REQ_DCACHE = 1'b1;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   // A port requests a transfer when either strobe is high.
   function automatic logic is_req(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin select: on a tie the requester that did not win last
// time is chosen; a lone requester always wins.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic valid,
   output logic id
);

   // Pick the winner from the current requests and the previous winner.
   always_comb begin
      valid = req0 | req1;
      if (req0 && req1) begin
         id = ~last_grant;
      end else if (req1) begin
         id = REQ_DCACHE;
      end else begin
         id = REQ_ICACHE;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one block-wide data memory between the icache (c0) and dcache (c1),
// one transfer at a time, with a hung-memory watchdog.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int BLOCK_W        = BLOCK_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               c0_read,
   input  logic               c0_write,
   input  logic [ADDR_W-1:0]  c0_address,
   input  logic [BLOCK_W-1:0] c0_writedata,
   output logic [BLOCK_W-1:0] c0_readdata,
   output logic               c0_busywait,
   input  logic               c1_read,
   input  logic               c1_write,
   input  logic [ADDR_W-1:0]  c1_address,
   input  logic [BLOCK_W-1:0] c1_writedata,
   output logic [BLOCK_W-1:0] c1_readdata,
   output logic               c1_busywait,
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_busywait,
   output logic               grant_id,
   output logic               timeout_err
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic               c0_req, c1_req, pick_valid, pick_id;
   logic [1:0]         state_q, state_d;
   op_e                op_q, op_d;
   logic               mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
   logic [BLOCK_W-1:0] mem_writedata_q, mem_writedata_d;
   logic [BLOCK_W-1:0] c0_readdata_q, c0_readdata_d, c1_readdata_q, c1_readdata_d;
   logic               grant_id_q, grant_id_d, last_grant_q, last_grant_d;
   logic [WD_W-1:0]    wdog_q, wdog_d;
   logic               timeout_err_q, timeout_err_d;

   assign c0_req = is_req(c0_read, c0_write);
   assign c1_req = is_req(c1_read, c1_write);

   // Stall is released only for the owner, and only during its DONE cycle.
   assign c0_busywait = c0_req && !((state_q == S_DONE) && (grant_id_q == REQ_ICACHE));
   assign c1_busywait = c1_req && !((state_q == S_DONE) && (grant_id_q == REQ_DCACHE));

   rr_pick2 u_pick (
      .req0       (c0_req),
      .req1       (c1_req),
      .last_grant (last_grant_q),
      .valid      (pick_valid),
      .id         (pick_id)
   );

   // Arbitration FSM, request latching, read-data capture and watchdog.
   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      mem_read_d      = mem_read_q;
      mem_write_d     = mem_write_q;
      mem_address_d   = mem_address_q;
      mem_writedata_d = mem_writedata_q;
      c0_readdata_d   = c0_readdata_q;
      c1_readdata_d   = c1_readdata_q;
      grant_id_d      = grant_id_q;
      last_grant_d    = last_grant_q;
      wdog_d          = wdog_q;
      timeout_err_d   = timeout_err_q;
      case (state_q)
         S_IDLE: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (pick_valid) begin
               state_d    = S_GRANT;
               grant_id_d = pick_id;
               wdog_d     = {WD_W{1'b0}};
               // Read wins when a port raises both strobes.
               if (pick_id == REQ_DCACHE) begin
                  op_d            = c1_read ? OP_READ : OP_WRITE;
                  mem_address_d   = c1_address;
                  mem_writedata_d = c1_writedata;
               end else begin
                  op_d            = c0_read ? OP_READ : OP_WRITE;
                  mem_address_d   = c0_address;
                  mem_writedata_d = c0_writedata;
               end
               mem_read_d  = (op_d == OP_READ);
               mem_write_d = (op_d == OP_WRITE);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            // wdog_q == 0 marks the first GRANT cycle, where busywait is not yet valid.
            if ((wdog_q != {WD_W{1'b0}}) && !mem_busywait) begin
               state_d     = S_DONE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if ((op_q == OP_READ) && (grant_id_q == REQ_DCACHE)) begin
                  c1_readdata_d = mem_readdata;
               end else if (op_q == OP_READ) begin
                  c0_readdata_d = mem_readdata;
               end else begin
                  c0_readdata_d = c0_readdata_q;
               end
            end else if (wdog_q == WD_LAST) begin
               state_d       = S_DONE;
               mem_read_d    = 1'b0;
               mem_write_d   = 1'b0;
               timeout_err_d = 1'b1;
            end else begin
               wdog_d = wdog_q + WD_W'(1'b1);
            end
         end
         S_DONE: begin
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            last_grant_d = grant_id_q;
            state_d      = S_IDLE;
         end
         default: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers; c0 wins the first tie after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         op_q            <= OP_READ;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= {ADDR_W{1'b0}};
         mem_writedata_q <= {BLOCK_W{1'b0}};
         c0_readdata_q   <= {BLOCK_W{1'b0}};
         c1_readdata_q   <= {BLOCK_W{1'b0}};
         grant_id_q      <= REQ_ICACHE;
         last_grant_q    <= REQ_DCACHE;
         wdog_q          <= {WD_W{1'b0}};
         timeout_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         mem_address_q   <= mem_address_d;
         mem_writedata_q <= mem_writedata_d;
         c0_readdata_q   <= c0_readdata_d;
         c1_readdata_q   <= c1_readdata_d;
         grant_id_q      <= grant_id_d;
         last_grant_q    <= last_grant_d;
         wdog_q          <= wdog_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_address   = mem_address_q;
   assign mem_writedata = mem_writedata_q;
   assign c0_readdata   = c0_readdata_q;
   assign c1_readdata   = c1_readdata_q;
   assign grant_id      = grant_id_q;
   assign timeout_err   = timeout_err_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single block-wide data memory (28-bit block address, 128-bit block, read/write/busywait handshake) between the instruction cache (port c0) and the data cache (port c1).
- Sits between both caches and the memory.
- Serialises transfers, relays the memory's busywait, and separates transfers with a one-cycle idle gap so the memory's byte counter restarts cleanly.
- Includes a watchdog that flags a hung memory.

Parameters:
ADDR_W, 28, block address width
BLOCK_W, 128, block data width
TIMEOUT_CYCLES, 64, max cycles in GRANT before forced abort

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
c0_read  in  1  icache read request
c0_write  in  1  icache write request
c0_address  in  ADDR_W  icache block address
c0_writedata  in  BLOCK_W  icache write block
c0_readdata  out  BLOCK_W  icache read block, registered
c0_busywait  out  1  stall to icache
c1_read, c1_write, c1_address, c1_writedata, c1_readdata, c1_busywait  same as c0, for dcache
mem_read  out  1  read to memory
mem_write  out  1  write to memory
mem_address  out  ADDR_W  block address to memory
mem_writedata  out  BLOCK_W  write block to memory
mem_readdata  in  BLOCK_W  block from memory
mem_busywait  in  1  memory busy
grant_id  out  1  requester owning current/last transfer
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async, immediate): state=IDLE; mem_read=mem_write=0; mem_address=0; mem_writedata=0; c0/c1_readdata=0; grant_id=0; timeout_err=0; watchdog=0; last_grant=1 (c0 wins first tie).
- Request: cX_req = cX_read | cX_write. If read and write are both high, the arbiter treats it as a read.
- cX_busywait = cX_req && !(state==DONE && grant_id==X). Combinational. During reset it follows cX_req.
- State IDLE:
  - mem_read=mem_write=0.
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester != last_grant (round-robin).
  - On grant: latch op, address and writedata into mem_* registers; set grant_id; clear watchdog; go to GRANT.
- State GRANT:
  - mem_read or mem_write is held high from the latched op; address and data stay stable.
  - First GRANT cycle: mem_busywait is ignored (minimum one cycle).
  - Later cycles, mem_busywait==1: watchdog increments.
  - Later cycles, mem_busywait==0 (completion, sampled at posedge): for reads, capture mem_readdata into c{grant_id}_readdata. Go to DONE.
  - Watchdog reaches TIMEOUT_CYCLES: set timeout_err, leave readdata unchanged, go to DONE.
- State DONE:
  - Exactly one cycle; mem_read=mem_write=0.
  - The granted requester sees busywait=0 this cycle.
  - last_grant := grant_id; next state IDLE.
  - A request still held at the following IDLE counts as a new request.
  - Earliest back-to-back grant: the cycle after DONE, giving a 1-cycle gap on mem_read/mem_write.
- Request withdrawn mid-GRANT: the memory transfer still runs to completion (it cannot be aborted). Read data is still captured; no busywait effect.
- Other requester's readdata is never modified.
- grant_id holds its value through IDLE until the next grant.
- timeout_err clears only on reset.
- Latency: request at IDLE posedge N → GRANT at N+1. With a memory needing K busy cycles, completion is sampled at N+1+K and DONE falls at N+2+K.

Decomposition:
- Package dmem_arb_pkg holds:
  - ADDR_W and BLOCK_W defaults.
  - State encoding: IDLE=2'b00, GRANT=2'b01, DONE=2'b10.
  - Requester IDs: REQ_ICACHE=0, REQ_DCACHE=1.
  - Op encoding: OP_READ, OP_WRITE.
- One sub-module, rr_pick2: combinational two-way round-robin select from (req0, req1, last_grant) giving (valid, id).
- FSM, latches and watchdog stay in dmem_arbiter.

Test Plan:
1. c0_read addr=28'h0000010 alone; memory model busy 16 cycles returning 128'hA5..A5 → mem_read high 17 cycles, mem_address=28'h0000010, c0_readdata=128'hA5..A5, c0_busywait low exactly one cycle (DONE), c1 outputs untouched.
2. c0_read and c1_write asserted the same cycle after reset → c0 granted first. After DONE plus a 1-cycle mem_read/mem_write gap, c1 is granted with mem_write=1 and mem_writedata=c1_writedata. Then with both requesting again, c1 loses → strict alternation 0,1,0,1.
3. c1_read and c1_write both high, addr=28'h3 → only mem_read asserted; data returned on c1_readdata.
4. Memory model holds mem_busywait=1 forever → after 64 GRANT cycles timeout_err=1 and stays high. Requester sees one busywait-low cycle; readdata is unchanged. Next request is served normally.
5. Reset pulsed for 1 cycle mid-GRANT → mem_read/mem_write drop asynchronously, all outputs return to reset values, next grant goes to c0.
6. c0_read withdrawn 3 cycles into GRANT → mem_read stays high until memory completes; c0_readdata is updated; DONE and IDLE follow normally.
